// File: rtl/ram8_pkg.sv
// Shared constants for the ram8 storage tile: word geometry, FSM state
// encodings and the 8-way one-hot write-enable decoder.
package ram8_pkg;

    localparam int WORD_W      = 16;
    localparam int RAM8_DEPTH  = 8;
    localparam int RAM8_ADDR_W = 3;

    localparam logic [0:0] RAM8_IDLE  = 1'b0;
    localparam logic [0:0] RAM8_SWEEP = 1'b1;

    function automatic logic [RAM8_DEPTH-1:0] decode8(
        input logic [RAM8_ADDR_W-1:0] sel,
        input logic                   en
    );
        logic [RAM8_DEPTH-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/register16.sv
// Single storage word with synchronous load, synchronous zero (zero wins)
// and asynchronous active-high reset.
module register16
    import ram8_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             zero,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (zero) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram8.sv
// Eight-word RAM with combinational read mux and a self-timed clear sweep.
// Optional macro RAM8_BYPASS_EN adds same-cycle write-through on out.
module ram8
    import ram8_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = RAM8_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic [RAM8_ADDR_W-1:0] address,
    input  logic                   load,
    input  logic                   clear,
    output logic [WIDTH-1:0]       out,
    output logic                   busy
);

    logic [0:0]             state;
    logic [0:0]             state_next;
    logic [RAM8_ADDR_W-1:0] cnt;
    logic [RAM8_ADDR_W-1:0] cnt_next;
    logic                   sweeping;
    logic [RAM8_DEPTH-1:0]  load_en;
    logic [RAM8_DEPTH-1:0]  zero_en;
    logic [WIDTH-1:0]       word [DEPTH];

    assign sweeping = (state == RAM8_SWEEP);
    assign busy     = sweeping;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RAM8_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A clear seen while already sweeping is ignored; cnt wraps 7 -> 0 on exit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == RAM8_IDLE) begin
            if (clear) begin
                state_next = RAM8_SWEEP;
                cnt_next   = '0;
            end
        end else begin
            cnt_next = cnt + 3'd1;
            if (cnt == 3'd7) begin
                state_next = RAM8_IDLE;
            end
        end
    end

    // User writes are dropped while the sweep owns the write port.
    assign load_en = decode8(address, load && !sweeping);
    assign zero_en = decode8(cnt, sweeping);

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register16 #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk  (clk),
            .reset(reset),
            .load (load_en[i]),
            .zero (zero_en[i]),
            .d    (in),
            .q    (word[i])
        );
    end

`ifdef RAM8_BYPASS_EN
    assign out = (load && !sweeping) ? in : word[address];
`else
    assign out = word[address];
`endif

endmodule

// File: tb/tb_ram8.sv
// Directed, table-driven bench for ram8: reset, fill/readback, clear sweep,
// blocked writes, simultaneous load+clear, and reset during a sweep.
module tb_ram8;

    typedef struct {
        logic        load;
        logic        clear;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic        exp_busy;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic [2:0]  address;
    logic        load;
    logic        clear;
    logic [15:0] out;
    logic        busy;

    int passed;
    int total;
    vec_t vecs[$];

    ram8 dut (
        .clk    (clk),
        .reset  (reset),
        .in     (din),
        .address(address),
        .load   (load),
        .clear  (clear),
        .out    (out),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic clr, input logic [2:0] a,
                       input logic [15:0] d, input logic [15:0] eo, input logic eb);
        vec_t v;
        v.load = ld; v.clear = clr; v.addr = a; v.din = d;
        v.exp_out = eo; v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    logic [15:0] fill [8];

    initial begin
        passed = 0;
        total  = 0;
        fill[0] = 16'h3141; fill[1] = 16'h5926; fill[2] = 16'h5358; fill[3] = 16'h9793;
        fill[4] = 16'h2384; fill[5] = 16'h6264; fill[6] = 16'h3383; fill[7] = 16'h2795;

        // Fill and read back every word.
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 3'(i), fill[i], fill[i], 1'b0);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 3'(i), 16'h0000, fill[i], 1'b0);
        // Clear at edge K; word[i] zeroed at K+1+i; writes and re-clear ignored.
        add(1'b0, 1'b1, 3'd0, 16'h0000, 16'h3141, 1'b1);  // K
        add(1'b1, 1'b0, 3'd5, 16'hBEEF, 16'h6264, 1'b1);  // K+1
        add(1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000, 1'b1);  // K+2
        add(1'b0, 1'b0, 3'd3, 16'h0000, 16'h9793, 1'b1);  // K+3
        add(1'b0, 1'b0, 3'd2, 16'h0000, 16'h0000, 1'b1);  // K+4
        add(1'b1, 1'b0, 3'd5, 16'hBEEF, 16'h6264, 1'b1);  // K+5
        add(1'b0, 1'b0, 3'd6, 16'h0000, 16'h3383, 1'b1);  // K+6
        add(1'b0, 1'b0, 3'd7, 16'h0000, 16'h2795, 1'b1);  // K+7
        add(1'b0, 1'b0, 3'd7, 16'h0000, 16'h0000, 1'b0);  // K+8
        add(1'b0, 1'b0, 3'd5, 16'h0000, 16'h0000, 1'b0);
        add(1'b0, 1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0);
        // Simultaneous load+clear: write lands, then the sweep zeroes it at K+8.
        add(1'b1, 1'b1, 3'd7, 16'hAAAA, 16'hAAAA, 1'b1);
        for (int i = 1; i < 8; i++) add(1'b0, 1'b0, 3'd7, 16'h0000, 16'hAAAA, 1'b1);
        add(1'b0, 1'b0, 3'd7, 16'h0000, 16'h0000, 1'b0);

        reset = 1'b1; din = '0; address = '0; load = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            check($sformatf("reset_out[%0d]", i), out, 16'h0000);
        end
        check("reset_busy", {15'd0, busy}, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            load = vecs[i].load; clear = vecs[i].clear;
            address = vecs[i].addr; din = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].exp_busy});
        end

        // Reset in the middle of a sweep aborts it and zeroes everything at once.
        @(negedge clk); load = 1'b1; clear = 1'b0; address = 3'd3; din = 16'h1111;
        @(negedge clk); address = 3'd6; din = 16'h2222;
        @(negedge clk); load = 1'b0; clear = 1'b1;      // edge K
        @(negedge clk); clear = 1'b0;
        repeat (3) @(negedge clk);                      // past K+3
        address = 3'd6;
        #1;
        check("presreset_word6", out, 16'h2222);
        check("presreset_busy", {15'd0, busy}, 16'h0001);
        reset = 1'b1;
        #1;
        check("midreset_busy", {15'd0, busy}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            check($sformatf("midreset_out[%0d]", i), out, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b0;
        load = 1'b1; din = 16'h1234; address = 3'd2;
        #1;
`ifdef RAM8_BYPASS_EN
        check("bypass_before_edge", out, 16'h1234);
`else
        check("nobypass_before_edge", out, 16'h0000);
`endif
        @(posedge clk);
        #1;
        check("write_after_reset", out, 16'h1234);
        @(negedge clk); load = 1'b0;
        #1;
        check("readback_after_reset", out, 16'h1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
